// File: rtl/adder_pkg.sv
// Shared types and defaults for the pipelined adder.
// Imported by the adder top and its bench.
package adder_pkg;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
  } add_flags_t;

  localparam int ADD_WIDTH  = 32;
  localparam int ADD_STAGES = 4;

  // Width must split evenly into 1..WIDTH chunks.
  function automatic bit geom_ok(int w, int s);
    return (s >= 1) && (s <= w) && ((w % s) == 0);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// CW-bit ripple adder built from full_adder cells.
// Exposes the carry into the MSB for overflow detection.
module add_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] o,
  output logic          co,
  output logic          c_msb
);

  logic [CW:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CW; i++) begin : g_bit
    full_adder u_fa (
      .a (a[i]),
      .b (b[i]),
      .ci(c[i]),
      .s (o[i]),
      .co(c[i+1])
    );
  end

  assign co    = c[CW];
  assign c_msb = c[CW-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Leaf of every chunk carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/sub: one CW-bit chunk per stage.
// Final stage register is the output register.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADD_WIDTH,
  parameter int STAGES = ADD_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = WIDTH / STAGES;

  if (!geom_ok(WIDTH, STAGES)) begin : g_bad_geom
    $error("pipe_adder: WIDTH must be a multiple of STAGES");
  end

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  add_flags_t       flags;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign b_eff    = b ^ {WIDTH{sub}};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // RW: operand bits not yet consumed on entry.
    // PW: result bits assembled after this stage.
    localparam int RW = WIDTH - k * CW;
    localparam int PW = (k + 1) * CW;

    logic [RW-1:0] ra;
    logic [RW-1:0] rb;
    logic          vin;
    logic          cin;
    logic          zin;
    logic [CW-1:0] sum;
    logic          co;
    logic          c_msb;
    logic [PW-1:0] nxt_r;
    logic          v_q;
    logic          c_q;
    logic          z_q;
    logic [PW-1:0] r_q;

    if (k == 0) begin : g_src
      assign vin   = in_valid;
      assign ra    = a;
      assign rb    = b_eff;
      assign cin   = sub;
      assign zin   = 1'b1;
      assign nxt_r = sum;
    end else begin : g_src
      assign vin   = g_stage[k-1].v_q;
      assign ra    = g_stage[k-1].g_skew.sa_q;
      assign rb    = g_stage[k-1].g_skew.sb_q;
      assign cin   = g_stage[k-1].c_q;
      assign zin   = g_stage[k-1].z_q;
      assign nxt_r = {sum, g_stage[k-1].r_q};
    end

    add_chunk #(
      .CW(CW)
    ) u_chunk (
      .a    (ra[CW-1:0]),
      .b    (rb[CW-1:0]),
      .ci   (cin),
      .o    (sum),
      .co   (co),
      .c_msb(c_msb)
    );

    // Stage register: valid, chunk carry, running zero, result so far.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        z_q <= 1'b0;
        r_q <= '0;
      end else if (!stall) begin
        v_q <= vin;
        c_q <= co;
        z_q <= zin & (sum == '0);
        r_q <= nxt_r;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [RW-CW-1:0] sa_q;
      logic [RW-CW-1:0] sb_q;
      logic             unused_msb;

      assign unused_msb = c_msb;

      // Skew registers carry the upper operand bits forward.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sa_q <= '0;
          sb_q <= '0;
        end else if (!stall) begin
          sa_q <= ra[RW-1:CW];
          sb_q <= rb[RW-1:CW];
        end
      end
    end else begin : g_last
      logic ovf_q;

      // Signed overflow: carry into MSB differs from carry out.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= c_msb ^ co;
        end
      end
    end
  end

  assign flags.carry = g_stage[STAGES-1].c_q;
  assign flags.ovf   = g_stage[STAGES-1].g_last.ovf_q;
  assign flags.zero  = g_stage[STAGES-1].z_q;

  assign out_valid = g_stage[STAGES-1].v_q;
  assign o         = g_stage[STAGES-1].r_q;
  assign carry     = flags.carry;
  assign ovf       = flags.ovf;
  assign zero      = flags.zero;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder at STAGES = 4, 1 and 32.
// Queue model with per-op countdown, checked every cycle.
module tb_pipe_adder;

  localparam int ND = 3;

  typedef struct {
    logic [31:0] o;
    logic        c;
    logic        v;
    logic        z;
    int          rem;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        ir [ND];
  logic        ov [ND];
  logic        oc [ND];
  logic        ovf_o [ND];
  logic        oz [ND];
  logic [31:0] oo [ND];

  ent_t mq [ND][$];
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 0;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(32), .STAGES(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ir[0]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[0]), .out_ready(out_ready), .o(oo[0]),
    .carry(oc[0]), .ovf(ovf_o[0]), .zero(oz[0])
  );

  pipe_adder #(.WIDTH(32), .STAGES(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ir[1]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[1]), .out_ready(out_ready), .o(oo[1]),
    .carry(oc[1]), .ovf(ovf_o[1]), .zero(oz[1])
  );

  pipe_adder #(.WIDTH(32), .STAGES(32)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ir[2]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[2]), .out_ready(out_ready), .o(oo[2]),
    .carry(oc[2]), .ovf(ovf_o[2]), .zero(oz[2])
  );

  function automatic int depth_of(int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  // Returns {carry, ovf, zero, result}.
  function automatic logic [34:0] ref_add(
    input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [31:0] r;
    logic        c;
    logic        v;
    logic [32:0] wide;
    wide = {1'b0, x} + {1'b0, y};
    r = s ? x - y : x + y;
    c = s ? (x >= y) : wide[32];
    if (s) v = (x[31] != y[31]) && (r[31] != x[31]);
    else   v = (x[31] == y[31]) && (r[31] != x[31]);
    return {c, v, (r == 32'd0), r};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Model: on each moving edge every in-flight op counts down.
  always @(posedge clk) begin : model
    logic        mv;
    logic [34:0] r;
    ent_t        e;
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        mq[d].delete();
        chk_en = 1;
      end else begin
        mv = (mq[d].size() > 0) && (mq[d][0].rem == 0);
        if (!(mv && !out_ready)) begin
          if (mv) void'(mq[d].pop_front());
          for (int i = 0; i < mq[d].size(); i++)
            mq[d][i].rem = mq[d][i].rem - 1;
          if (in_valid) begin
            r = ref_add(a, b, sub);
            e.o = r[31:0];
            e.c = r[34];
            e.v = r[33];
            e.z = r[32];
            e.rem = depth_of(d) - 1;
            mq[d].push_back(e);
          end
        end
      end
    end
  end

  // Compare every DUT against the model away from the edge.
  always @(negedge clk) begin : compare
    logic mv;
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        mv = (mq[d].size() > 0) && (mq[d][0].rem == 0);
        chk($sformatf("out_valid[%0d]", d), 64'(ov[d]), 64'(mv));
        chk($sformatf("in_ready[%0d]", d), 64'(ir[d]),
            64'(!(mv && !out_ready)));
        if (mv)
          chk($sformatf("result[%0d] {c,v,z,o}", d),
              64'({oc[d], ovf_o[d], oz[d], oo[d]}),
              64'({mq[d][0].c, mq[d][0].v, mq[d][0].z, mq[d][0].o}));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] edge_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_op();
    a = edge_val();
    b = ($urandom_range(0, 7) == 0) ? a : edge_val();
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic set_op(input logic [31:0] x, input logic [31:0] y,
                        input logic s);
    a = x;
    b = y;
    sub = s;
  endtask

  initial begin : stim
    int  lat [ND];
    logic [31:0] val [ND];
    int  run;
    int  best;
    int  sent;
    int  hold;
    bit  dropped;
    bit  acc;

    chk("ref ffff+1", 64'(ref_add(32'h0000_FFFF, 32'h1, 1'b0)),
        64'({3'b000, 32'h0001_0000}));
    chk("ref 5-5", 64'(ref_add(32'd5, 32'd5, 1'b1)),
        64'({3'b101, 32'h0}));
    chk("ref 0-1", 64'(ref_add(32'd0, 32'd1, 1'b1)),
        64'({3'b000, 32'hFFFF_FFFF}));
    chk("ref max+1", 64'(ref_add(32'h7FFF_FFFF, 32'h1, 1'b0)),
        64'({3'b010, 32'h8000_0000}));
    chk("ref min-1", 64'(ref_add(32'h8000_0000, 32'h1, 1'b1)),
        64'({3'b110, 32'h7FFF_FFFF}));

    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset out_valid[%0d]", d), 64'(ov[d]), 64'd0);
      chk($sformatf("reset o[%0d]", d), 64'(oo[d]), 64'd0);
      chk($sformatf("reset flags[%0d]", d),
          64'({oc[d], ovf_o[d], oz[d]}), 64'd0);
      chk($sformatf("reset in_ready[%0d]", d), 64'(ir[d]), 64'd1);
    end

    set_op(32'h0000_FFFF, 32'h1, 1'b0);
    in_valid = 1'b1;
    for (int d = 0; d < ND; d++) begin
      lat[d] = 0;
      val[d] = '0;
    end
    for (int n = 1; n <= 40; n++) begin
      step();
      if (n == 1) in_valid = 1'b0;
      for (int d = 0; d < ND; d++)
        if (ov[d] && lat[d] == 0) begin
          lat[d] = n;
          val[d] = oo[d];
        end
    end
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("latency[%0d]", d), 64'(lat[d]),
          64'(depth_of(d)));
      chk($sformatf("first o[%0d]", d), 64'(val[d]),
          64'h0001_0000);
    end

    in_valid = 1'b1;
    set_op(32'd5, 32'd5, 1'b1);
    step();
    set_op(32'd0, 32'd1, 1'b1);
    step();
    set_op(32'h7FFF_FFFF, 32'h1, 1'b0);
    step();
    set_op(32'h8000_0000, 32'h1, 1'b1);
    step();
    in_valid = 1'b0;
    repeat (40) step();

    run = 0;
    best = 0;
    in_valid = 1'b1;
    for (int n = 0; n < 48; n++) begin
      if (n < 8) rand_op();
      else in_valid = 1'b0;
      step();
      if (ov[0]) begin
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
    end
    chk("back-to-back run", 64'(best), 64'd8);

    sent = 0;
    hold = 0;
    dropped = 0;
    in_valid = 1'b1;
    rand_op();
    for (int n = 0; n < 60; n++) begin
      if (!dropped && ov[0]) begin
        dropped = 1;
        hold = 3;
      end
      out_ready = (hold == 0);
      if (hold > 0) hold--;
      #1;
      acc = in_valid && ir[0];
      step();
      if (acc) begin
        sent++;
        if (sent < 6) rand_op();
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    chk("backpressure ops accepted", 64'(sent), 64'd6);
    repeat (40) step();

    in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      rand_op();
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      chk("post-reset out_valid", 64'(ov[0]), 64'd0);
      step();
    end
    repeat (40) step();

    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_op();
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
